// File: rtl/game_switch_mux.sv
// rtl/game_switch_mux.sv - console game arbiter: power-up blank, select, play, pause, game-over
// Routes the active core's RGB/score to the display and keeps a per-slot best score.
module game_switch_mux #(
  parameter int          NUM_GAMES   = 4,
  parameter int          COLOR_W     = 4,
  parameter int          SCORE_W     = 14,
  parameter int          WAIT_CYCLES = 1024,
  parameter logic [7:0]  PAUSE_KEY   = 8'h76,
  parameter logic [7:0]  RETURN_KEY  = 8'h5A,
  localparam int         AW          = (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1,
  localparam int         CW          = 3 * COLOR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid,
  input  logic [7:0]                   keyboard,
  input  logic [8*NUM_GAMES-1:0]       game_keys,
  input  logic [CW*NUM_GAMES-1:0]      rgb_game,
  input  logic [CW-1:0]                rgb_select,
  input  logic [CW-1:0]                rgb_death,
  input  logic [NUM_GAMES-1:0]         game_over,
  input  logic [SCORE_W*NUM_GAMES-1:0] score_game,
  output logic [COLOR_W-1:0]           red,
  output logic [COLOR_W-1:0]           green,
  output logic [COLOR_W-1:0]           blue,
  output logic [SCORE_W-1:0]           score,
  output logic [SCORE_W-1:0]           best_score,
  output logic [NUM_GAMES-1:0]         game_rst,
  output logic [NUM_GAMES-1:0]         game_freeze,
  output logic [AW-1:0]                active_game,
  output logic [2:0]                   state_out
);

  localparam int WCW = $clog2(WAIT_CYCLES + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_SELECT = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSE  = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t               r_state;
  logic [WCW-1:0]       r_wait_cnt;
  logic [COLOR_W-1:0]   r_red, r_green, r_blue;
  logic [SCORE_W-1:0]   r_score, r_best_score;
  logic [SCORE_W-1:0]   r_best [NUM_GAMES];
  logic [NUM_GAMES-1:0] r_game_rst, r_game_freeze;
  logic [AW-1:0]        r_active;

  logic [CW-1:0]        w_rgb_act;
  logic [SCORE_W-1:0]   w_score_act, w_best_act;
  logic                 w_over_act;
  logic                 w_hit;
  logic [AW-1:0]        w_hit_idx;
  logic [COLOR_W-1:0]   w_act_r, w_act_g, w_act_b;

  always_comb begin
    w_rgb_act   = rgb_game[CW-1:0];
    w_score_act = score_game[SCORE_W-1:0];
    w_best_act  = r_best[0];
    w_over_act  = game_over[0];
    for (int i = 0; i < NUM_GAMES; i++) begin
      if (AW'(i) == r_active) begin
        w_rgb_act   = rgb_game[CW*i +: CW];
        w_score_act = score_game[SCORE_W*i +: SCORE_W];
        w_best_act  = r_best[i];
        w_over_act  = game_over[i];
      end
    end
    // Scan from the top so the lowest matching slot wins on duplicate codes.
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_GAMES - 1; i >= 0; i--) begin
      if (game_keys[8*i +: 8] == keyboard) begin
        w_hit     = 1'b1;
        w_hit_idx = AW'(i);
      end
    end
  end

  assign w_act_r = w_rgb_act[CW-1 -: COLOR_W];
  assign w_act_g = w_rgb_act[2*COLOR_W-1 -: COLOR_W];
  assign w_act_b = w_rgb_act[COLOR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_WAIT;
      r_wait_cnt    <= '0;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_score       <= '0;
      r_best_score  <= '0;
      r_game_rst    <= '1;
      r_game_freeze <= '0;
      r_active      <= '0;
      for (int i = 0; i < NUM_GAMES; i++) r_best[i] <= '0;
    end else begin
      r_best_score <= w_best_act;
      case (r_state)
        S_WAIT: begin
          {r_red, r_green, r_blue} <= '0;
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (r_wait_cnt == WAIT_LAST) r_state <= S_SELECT;
        end
        S_SELECT: begin
          {r_red, r_green, r_blue} <= rgb_select;
          if (valid && w_hit) begin
            r_active              <= w_hit_idx;
            r_game_rst[w_hit_idx] <= 1'b0;
            r_score               <= '0;
            r_state               <= S_PLAY;
          end
        end
        S_PLAY: begin
          {r_red, r_green, r_blue} <= w_rgb_act;
          r_score <= w_score_act;
          // Game-over beats a pause request arriving on the same cycle.
          if (w_over_act) begin
            r_game_rst[r_active] <= 1'b1;
            r_state              <= S_OVER;
            if (w_score_act > w_best_act) begin
              r_best[r_active] <= w_score_act;
              r_best_score     <= w_score_act;
            end
          end else if (valid && keyboard == PAUSE_KEY) begin
            r_game_freeze[r_active] <= 1'b1;
            r_state                 <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          r_red   <= w_act_r >> 1;
          r_green <= w_act_g >> 1;
          r_blue  <= w_act_b >> 1;
          if (valid && keyboard == PAUSE_KEY) begin
            r_game_freeze <= '0;
            r_state       <= S_PLAY;
          end else if (valid && keyboard == RETURN_KEY) begin
            r_game_rst[r_active] <= 1'b1;
            r_game_freeze        <= '0;
            r_state              <= S_SELECT;
          end
        end
        S_OVER: begin
          {r_red, r_green, r_blue} <= rgb_death;
          if (valid && keyboard == RETURN_KEY) r_state <= S_SELECT;
        end
        default: begin
          {r_red, r_green, r_blue} <= '0;
          r_state <= S_WAIT;
        end
      endcase
    end
  end

  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign score       = r_score;
  assign best_score  = r_best_score;
  assign game_rst    = r_game_rst;
  assign game_freeze = r_game_freeze;
  assign active_game = r_active;
  assign state_out   = r_state;

endmodule

// File: tb/tb_game_switch_mux.sv
// tb/tb_game_switch_mux.sv - randomized and directed bench for game_switch_mux with a behavioural model
module tb_game_switch_mux;

  localparam int NG = 4;
  localparam int WAITC = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  keyboard;
  logic [31:0] game_keys;
  logic [47:0] rgb_game;
  logic [11:0] rgb_select, rgb_death;
  logic [3:0]  game_over;
  logic [55:0] score_game;
  logic [3:0]  red, green, blue;
  logic [13:0] score, best_score;
  logic [3:0]  game_rst, game_freeze;
  logic [1:0]  active_game;
  logic [2:0]  state_out;

  logic [7:0]  keys    [NG];
  logic [11:0] g_rgb   [NG];
  logic [13:0] g_score [NG];
  logic [3:0]  g_over;

  int n_chk = 0;
  int n_err = 0;

  // Model state: abstract state number 0..4 with the values the outputs must show.
  int          m_init = 0;
  int          m_state, m_cnt, m_active;
  int          m_best [NG];
  int          e_r, e_g, e_b, e_score, e_best;
  logic [3:0]  e_rst, e_freeze;

  game_switch_mux dut (
    .clk(clk), .rst(rst), .valid(valid), .keyboard(keyboard),
    .game_keys(game_keys), .rgb_game(rgb_game), .rgb_select(rgb_select),
    .rgb_death(rgb_death), .game_over(game_over), .score_game(score_game),
    .red(red), .green(green), .blue(blue), .score(score), .best_score(best_score),
    .game_rst(game_rst), .game_freeze(game_freeze), .active_game(active_game),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NG; i++) begin
      game_keys[8*i +: 8]   = keys[i];
      rgb_game[12*i +: 12]  = g_rgb[i];
      score_game[14*i +: 14] = g_score[i];
    end
    game_over = g_over;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic show(input logic [11:0] c, input int div);
    e_r = int'(c[11:8]) / div;
    e_g = int'(c[7:4]) / div;
    e_b = int'(c[3:0]) / div;
  endtask

  task automatic model_step();
    int a;
    int hit;
    if (!rst) begin
      m_init = 1; m_state = 0; m_cnt = 0; m_active = 0;
      e_r = 0; e_g = 0; e_b = 0; e_score = 0; e_best = 0;
      e_rst = 4'hF; e_freeze = 4'h0;
      for (int i = 0; i < NG; i++) m_best[i] = 0;
      return;
    end
    if (m_init == 0) return;
    a = m_active;
    case (m_state)
      0: begin
        show(12'h000, 1);
        if (m_cnt == WAITC - 1) m_state = 1;
        m_cnt++;
      end
      1: begin
        show(rgb_select, 1);
        hit = -1;
        for (int i = 0; i < NG; i++) if (hit < 0 && keys[i] == keyboard) hit = i;
        if (valid && hit >= 0) begin
          m_active = hit; e_rst[hit] = 1'b0; e_score = 0; m_state = 2;
        end
      end
      2: begin
        show(g_rgb[a], 1);
        e_score = int'(g_score[a]);
        if (g_over[a]) begin
          e_rst[a] = 1'b1; m_state = 4;
          if (int'(g_score[a]) > m_best[a]) m_best[a] = int'(g_score[a]);
        end else if (valid && keyboard == 8'h76) begin
          e_freeze = 4'h1 << a; m_state = 3;
        end
      end
      3: begin
        show(g_rgb[a], 2);
        if (valid && keyboard == 8'h76) begin
          e_freeze = 4'h0; m_state = 2;
        end else if (valid && keyboard == 8'h5A) begin
          e_freeze = 4'h0; e_rst[a] = 1'b1; m_state = 1;
        end
      end
      default: begin
        show(rgb_death, 1);
        if (valid && keyboard == 8'h5A) m_state = 1;
      end
    endcase
    e_best = m_best[a];
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_init != 0) begin
      chk("state", 32'(state_out), 32'(m_state));
      chk("red", 32'(red), 32'(e_r));
      chk("green", 32'(green), 32'(e_g));
      chk("blue", 32'(blue), 32'(e_b));
      chk("score", 32'(score), 32'(e_score));
      chk("best_score", 32'(best_score), 32'(e_best));
      chk("game_rst", 32'(game_rst), 32'(e_rst));
      chk("game_freeze", 32'(game_freeze), 32'(e_freeze));
      chk("active_game", 32'(active_game), 32'(m_active));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    valid      = 1'b0;
    keyboard   = 8'($urandom);
    g_over     = 4'h0;
    rgb_select = 12'($urandom);
    rgb_death  = 12'($urandom);
    for (int i = 0; i < NG; i++) g_rgb[i] = 12'($urandom);
  endtask

  task automatic press(input logic [7:0] code);
    valid = 1'b1;
    keyboard = code;
    tick();
  endtask

  logic [11:0] sel_prev;

  initial begin
    keys[0] = 8'h16; keys[1] = 8'h1E; keys[2] = 8'h26; keys[3] = 8'h1E;
    for (int i = 0; i < NG; i++) begin
      g_rgb[i] = 12'h000;
      g_score[i] = 14'd0;
    end
    g_over = 4'h0; valid = 1'b0; keyboard = 8'h00;
    rgb_select = 12'h000; rgb_death = 12'h000;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk("lit_reset_state", 32'(state_out), 0);
    chk("lit_reset_rst", 32'(game_rst), 32'hF);
    chk("lit_reset_rgb", 32'({red, green, blue}), 0);

    for (int k = 0; k < WAITC - 1; k++) tick();
    chk("lit_wait_1023", 32'(state_out), 0);
    tick();
    chk("lit_select_1024", 32'(state_out), 1);
    sel_prev = rgb_select;
    tick();
    chk("lit_select_rgb", 32'({red, green, blue}), 32'(sel_prev));

    g_score[1] = 14'd37;
    press(8'h1E);
    chk("lit_play_state", 32'(state_out), 2);
    chk("lit_play_active", 32'(active_game), 1);
    chk("lit_play_rst", 32'(game_rst), 32'b1101);
    tick();
    chk("lit_play_score", 32'(score), 37);
    g_over[1] = 1'b1;
    tick();
    chk("lit_over_state", 32'(state_out), 4);
    chk("lit_over_rst", 32'(game_rst), 32'hF);
    chk("lit_best_37", 32'(best_score), 37);
    keyboard = 8'h5A;
    tick();
    chk("lit_over_novalid", 32'(state_out), 4);
    press(8'h5A);

    g_score[1] = 14'd20;
    press(8'h1E); tick();
    g_over[1] = 1'b1; tick();
    chk("lit_best_keep", 32'(best_score), 37);
    press(8'h5A);
    g_score[1] = 14'd50;
    press(8'h1E); tick();
    g_over[1] = 1'b1; tick();
    chk("lit_best_50", 32'(best_score), 50);
    press(8'h5A);

    press(8'h1E); tick();
    press(8'h76);
    chk("lit_pause_state", 32'(state_out), 3);
    chk("lit_pause_freeze", 32'(game_freeze), 32'b0010);
    g_rgb[1] = 12'hF83;
    tick();
    chk("lit_dim", 32'({red, green, blue}), 32'h741);
    g_over[1] = 1'b1;
    tick();
    chk("lit_pause_over_ign", 32'(state_out), 3);
    press(8'h76);
    chk("lit_resume", 32'(state_out), 2);
    press(8'h76);
    press(8'h5A);
    chk("lit_abort", 32'(state_out), 1);
    tick();
    chk("lit_abort_best", 32'(best_score), 50);

    press(8'h1E);
    g_over[2] = 1'b1;
    tick();
    chk("lit_inactive_over", 32'(state_out), 2);
    g_over[1] = 1'b1; valid = 1'b1; keyboard = 8'h76;
    tick();
    chk("lit_over_beats_pause", 32'(state_out), 4);
    press(8'h5A);
    press(8'h1E); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("lit_midgame_reset", 32'(state_out), 0);
    chk("lit_midgame_best", 32'(best_score), 0);
    chk("lit_midgame_active", 32'(active_game), 0);

    for (int k = 0; k < WAITC; k++) tick();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NG; i++) begin
        if ($urandom_range(0, 3) == 0) g_score[i] = 14'($urandom);
        g_over[i] = ($urandom_range(0, 24) == 0);
      end
      if ($urandom_range(0, 2) == 0) begin
        valid = 1'b1;
        case ($urandom_range(0, 6))
          0, 1, 2, 3: keyboard = keys[$urandom_range(0, NG - 1)];
          4:          keyboard = 8'h76;
          5:          keyboard = 8'h5A;
          default:    keyboard = 8'($urandom);
        endcase
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
